// File: rtl/instruction_fetch_unit.sv
// Core101 fetch stage: PC sequencing, instruction-memory handshake, output register
// with a one-entry skid buffer, and branch/jump redirect handling.
`timescale 1ns/1ps
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        fetch_clock_in,
   input  logic        fetch_reset_in,
   output logic [31:0] fetch_ins_mem_addr_out,
   output logic        fetch_ins_mem_req_out,
   input  logic        fetch_ins_mem_ack_in,
   input  logic [31:0] fetch_ins_mem_data_in,
   input  logic        fetch_redirect_in,
   input  logic [31:0] fetch_redirect_addr_in,
   output logic        fetch_ir_valid_out,
   input  logic        fetch_ir_ready_in,
   output logic [31:0] fetch_ir_out,
   output logic [31:0] fetch_pc_out,
   output logic        fetch_misaligned_out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   state_t      base_next_s;
   logic [31:0] pc_r;
   logic [31:0] drain_addr_r;
   logic        out_valid_r;
   logic [31:0] out_ir_r;
   logic [31:0] out_pc_r;
   logic        skid_valid_r;
   logic [31:0] skid_ir_r;
   logic [31:0] skid_pc_r;
   logic        misaligned_r;
   logic        req_s;
   logic [31:0] addr_s;
   logic        mem_ack_s;
   logic        fetched_s;
   logic        out_free_s;

   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

   assign mem_ack_s  = req_s & fetch_ins_mem_ack_in;
   assign fetched_s  = mem_ack_s & (state_r == ST_FETCH) & ~fetch_redirect_in;
   assign out_free_s = ~out_valid_r | fetch_ir_ready_in;

   assign fetch_ins_mem_addr_out = addr_s;
   assign fetch_ins_mem_req_out  = req_s;
   assign fetch_ir_valid_out     = out_valid_r;
   assign fetch_ir_out           = out_ir_r;
   assign fetch_pc_out           = out_pc_r;
   assign fetch_misaligned_out   = misaligned_r;

   // State register
   always_ff @(posedge fetch_clock_in or negedge fetch_reset_in) begin
      if (!fetch_reset_in) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state, memory request and address selection
   always_comb begin
      state_next_s = state_r;
      base_next_s  = state_r;
      req_s        = 1'b0;
      addr_s       = pc_r;
      case (state_r)
         ST_IDLE: begin
            base_next_s = ST_FETCH;
         end
         ST_FETCH: begin
            req_s = ~skid_valid_r;
         end
         ST_DRAIN: begin
            // the abandoned request must complete at its original address
            req_s  = 1'b1;
            addr_s = drain_addr_r;
            if (fetch_ins_mem_ack_in) begin
               base_next_s = ST_FETCH;
            end else begin
               base_next_s = ST_DRAIN;
            end
         end
         ST_ERROR: begin
            base_next_s = ST_ERROR;
         end
         default: begin
            base_next_s = ST_IDLE;
         end
      endcase
      if (fetch_redirect_in) begin
         if (is_misaligned(fetch_redirect_addr_in)) begin
            state_next_s = ST_ERROR;
         end else if (req_s && !fetch_ins_mem_ack_in) begin
            state_next_s = ST_DRAIN;
         end else begin
            state_next_s = ST_FETCH;
         end
      end else begin
         state_next_s = base_next_s;
      end
   end

   // PC, output register, skid buffer and misalignment flag
   always_ff @(posedge fetch_clock_in or negedge fetch_reset_in) begin
      if (!fetch_reset_in) begin
         pc_r         <= RESET_VECTOR;
         drain_addr_r <= RESET_VECTOR;
         out_valid_r  <= 1'b0;
         out_ir_r     <= NOP_INSTR;
         out_pc_r     <= 32'h0000_0000;
         skid_valid_r <= 1'b0;
         skid_ir_r    <= NOP_INSTR;
         skid_pc_r    <= 32'h0000_0000;
         misaligned_r <= 1'b0;
      end else if (fetch_redirect_in) begin
         out_valid_r  <= 1'b0;
         out_ir_r     <= NOP_INSTR;
         skid_valid_r <= 1'b0;
         if (is_misaligned(fetch_redirect_addr_in)) begin
            misaligned_r <= 1'b1;
         end else begin
            misaligned_r <= 1'b0;
            pc_r         <= fetch_redirect_addr_in;
            // a second redirect while draining keeps the original drain address
            if (state_r != ST_DRAIN) begin
               drain_addr_r <= pc_r;
            end
         end
      end else begin
         if (fetched_s) begin
            pc_r <= pc_r + 32'd4;
         end
         if (out_free_s) begin
            if (skid_valid_r) begin
               out_valid_r  <= 1'b1;
               out_ir_r     <= skid_ir_r;
               out_pc_r     <= skid_pc_r;
               skid_valid_r <= 1'b0;
            end else if (fetched_s) begin
               out_valid_r <= 1'b1;
               out_ir_r    <= fetch_ins_mem_data_in;
               out_pc_r    <= pc_r;
            end else if (out_valid_r) begin
               out_valid_r <= 1'b0;
               out_ir_r    <= NOP_INSTR;
            end
         end else if (fetched_s) begin
            skid_valid_r <= 1'b1;
            skid_ir_r    <= fetch_ins_mem_data_in;
            skid_pc_r    <= pc_r;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus pushes expected {pc, ir}
// pairs, a negedge monitor pops and compares each decode handshake.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] GARBAGE = 32'hDEAD_BEEF;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_data;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        ir_valid;
   logic        ir_ready;
   logic [31:0] ir;
   logic [31:0] pc_out;
   logic        misaligned;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int mem_waits = 0;
   int mem_budget = 0;
   int mem_wcnt = 0;
   logic [63:0] exp_q[$];

   instruction_fetch_unit dut (
      .fetch_clock_in         (clk),
      .fetch_reset_in         (rst_n),
      .fetch_ins_mem_addr_out (mem_addr),
      .fetch_ins_mem_req_out  (mem_req),
      .fetch_ins_mem_ack_in   (mem_ack),
      .fetch_ins_mem_data_in  (mem_data),
      .fetch_redirect_in      (redirect),
      .fetch_redirect_addr_in (redirect_addr),
      .fetch_ir_valid_out     (ir_valid),
      .fetch_ir_ready_in      (ir_ready),
      .fetch_ir_out           (ir),
      .fetch_pc_out           (pc_out),
      .fetch_misaligned_out   (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_instr(input logic [31:0] pc);
      exp_q.push_back({pc, word(pc)});
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         step();
         n++;
      end
      total_cnt++;
      if (exp_q.size() == 0) pass_cnt++;
      else $display("FAIL %s: timeout with %0d instructions outstanding, expected 0", name, exp_q.size());
   endtask

   // memory model: acks after mem_waits stall cycles while a budget remains
   initial begin
      mem_ack  = 1'b0;
      mem_data = GARBAGE;
      forever begin
         @(negedge clk);
         if (mem_req === 1'b1 && mem_budget > 0) begin
            if (mem_wcnt >= mem_waits) begin
               mem_ack  = 1'b1;
               mem_data = word(mem_addr);
               mem_wcnt = 0;
               mem_budget--;
            end else begin
               mem_ack  = 1'b0;
               mem_data = GARBAGE;
               mem_wcnt++;
            end
         end else begin
            mem_ack  = 1'b0;
            mem_data = GARBAGE;
            mem_wcnt = 0;
         end
      end
   end

   // decode-side monitor
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && ir_valid === 1'b1 && ir_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_instr_pc", pc_out, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", pc_out, e[63:32]);
               check("sb_ir", ir, e[31:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      redirect = 1'b0;
      redirect_addr = 32'h0;
      ir_ready = 1'b1;

      // zero-wait memory, ready=1
      do_reset();
      check("rst_req", {31'd0, mem_req}, 32'd0);
      check("rst_valid", {31'd0, ir_valid}, 32'd0);
      check("rst_ir", ir, NOP);
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_addr", mem_addr, 32'h0);
      check("rst_misaligned", {31'd0, misaligned}, 32'd0);
      mem_waits = 0;
      mem_budget = 4;
      expect_instr(32'h0); expect_instr(32'h4); expect_instr(32'h8); expect_instr(32'hC);
      rst_n = 1'b1;
      step();
      check("zw_req", {31'd0, mem_req}, 32'd1);
      check("zw_addr0", mem_addr, 32'h0);
      check("zw_valid_before", {31'd0, ir_valid}, 32'd0);
      step();
      check("zw_addr4", mem_addr, 32'h4);
      check("zw_valid_after", {31'd0, ir_valid}, 32'd1);
      step();
      check("zw_addr8", mem_addr, 32'h8);
      step();
      check("zw_addrC", mem_addr, 32'hC);
      wait_empty("zw_drain");

      // two wait states
      do_reset();
      mem_waits = 2;
      mem_budget = 2;
      expect_instr(32'h0); expect_instr(32'h4);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ws_addr_held", mem_addr, 32'h0);
         check("ws_req_held", {31'd0, mem_req}, 32'd1);
      end
      check("ws_valid_wait", {31'd0, ir_valid}, 32'd0);
      step();
      check("ws_addr4", mem_addr, 32'h4);
      check("ws_valid", {31'd0, ir_valid}, 32'd1);
      wait_empty("ws_drain");

      // backpressure into the skid register
      do_reset();
      mem_waits = 0;
      mem_budget = 3;
      ir_ready = 1'b0;
      expect_instr(32'h0); expect_instr(32'h4); expect_instr(32'h8);
      rst_n = 1'b1;
      step();
      step();
      check("bp_valid", {31'd0, ir_valid}, 32'd1);
      step();
      check("bp_req_drop", {31'd0, mem_req}, 32'd0);
      check("bp_addr8", mem_addr, 32'h8);
      step();
      check("bp_req_still_low", {31'd0, mem_req}, 32'd0);
      check("bp_pc_held", pc_out, 32'h0);
      ir_ready = 1'b1;
      step();
      check("bp_req_resume", {31'd0, mem_req}, 32'd1);
      check("bp_addr_resume", mem_addr, 32'h8);
      wait_empty("bp_drain");

      // redirect while the request to 0x8 is waiting
      do_reset();
      mem_waits = 2;
      mem_budget = 5;
      expect_instr(32'h0); expect_instr(32'h4); expect_instr(32'h100); expect_instr(32'h104);
      rst_n = 1'b1;
      for (int i = 0; i < 7; i++) step();
      check("rd_addr8", mem_addr, 32'h8);
      redirect = 1'b1;
      redirect_addr = 32'h100;
      step();
      redirect = 1'b0;
      check("rd_drain_addr", mem_addr, 32'h8);
      check("rd_drain_req", {31'd0, mem_req}, 32'd1);
      step();
      check("rd_drain_addr2", mem_addr, 32'h8);
      step();
      check("rd_new_addr", mem_addr, 32'h100);
      check("rd_no_stale", {31'd0, ir_valid}, 32'd0);
      wait_empty("rd_drain");

      // misaligned redirect, then recovery at 0x200
      redirect = 1'b1;
      redirect_addr = 32'h102;
      step();
      redirect = 1'b0;
      check("mis_flag", {31'd0, misaligned}, 32'd1);
      check("mis_req", {31'd0, mem_req}, 32'd0);
      check("mis_valid", {31'd0, ir_valid}, 32'd0);
      check("mis_addr_pc", mem_addr, 32'h108);
      step();
      check("mis_sticky", {31'd0, misaligned}, 32'd1);
      mem_waits = 0;
      mem_budget = 2;
      expect_instr(32'h200); expect_instr(32'h204);
      redirect = 1'b1;
      redirect_addr = 32'h200;
      step();
      redirect = 1'b0;
      check("mis_clear", {31'd0, misaligned}, 32'd0);
      check("mis_resume_addr", mem_addr, 32'h200);
      check("mis_resume_req", {31'd0, mem_req}, 32'd1);
      wait_empty("mis_drain");

      // PC wrap: same-cycle ack at 0x208 is discarded
      mem_budget = 3;
      expect_instr(32'hFFFF_FFFC); expect_instr(32'h0);
      redirect = 1'b1;
      redirect_addr = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      check("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
      check("wrap_discard", {31'd0, ir_valid}, 32'd0);
      step();
      check("wrap_addr_zero", mem_addr, 32'h0);
      wait_empty("wrap_drain");

      // asynchronous reset in the middle of a burst
      mem_budget = 3;
      expect_instr(32'h4); expect_instr(32'h8);
      step();
      step();
      step();
      check("mid_valid", {31'd0, ir_valid}, 32'd1);
      check("mid_req", {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_req", {31'd0, mem_req}, 32'd0);
      check("async_valid", {31'd0, ir_valid}, 32'd0);
      check("async_ir", ir, NOP);
      check("async_pc_out", pc_out, 32'h0);
      check("async_addr", mem_addr, 32'h0);
      check("async_misaligned", {31'd0, misaligned}, 32'd0);
      check("async_backlog", exp_q.size(), 32'd0);
      step();
      mem_budget = 1;
      expect_instr(32'h0);
      rst_n = 1'b1;
      step();
      check("restart_addr", mem_addr, 32'h0);
      check("restart_req", {31'd0, mem_req}, 32'd1);
      wait_empty("restart_drain");

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the Core101 datapath; drives the instruction memory interface.
- Maintains the PC and fetches one 32-bit word per memory handshake.
- Buffers each fetched instruction with its PC and hands it to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute and flushes in-flight work.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset.
NOP_INSTR, 32'h0000_0013, IR value driven while no valid instruction is held (RV32I addi x0,x0,0).

Ports:
fetch_clock_in  input  1  single clock, rising edge.
fetch_reset_in  input  1  asynchronous, active-low reset.
fetch_ins_mem_addr_out  output  32  instruction memory word address (byte address, [1:0]=0).
fetch_ins_mem_req_out  output  1  fetch request; addr stable while high until ack.
fetch_ins_mem_ack_in  input  1  memory completes request this cycle; data valid with it.
fetch_ins_mem_data_in  input  32  instruction word, sampled when req&ack.
fetch_redirect_in  input  1  one-cycle pulse: restart fetch at redirect address.
fetch_redirect_addr_in  input  32  redirect target.
fetch_ir_valid_out  output  1  IR/PC output holds a valid instruction.
fetch_ir_ready_in  input  1  decode accepts this cycle (transfer = valid&ready).
fetch_ir_out  output  32  instruction to decode.
fetch_pc_out  output  32  PC of fetch_ir_out.
fetch_misaligned_out  output  1  sticky: redirect target had [1:0]!=0.

Behaviour:
- Reset (fetch_reset_in=0, async):
  - pc=RESET_VECTOR; state=IDLE; req=0.
  - ir_valid=0; ir_out=NOP_INSTR; pc_out=0.
  - skid empty; misaligned=0.
- States: IDLE, FETCH, DRAIN, ERROR.
- IDLE: one cycle after reset release -> FETCH.
- FETCH:
  - req_out = !skid_valid; addr_out = pc.
  - On req&ack: pc <= pc+4 (mod 2^32 wrap).
  - Data+PC go to the output register if it is empty or drained this cycle, else to the skid register.
- Throughput:
  - Zero-wait memory (ack in the same cycle as req) gives one instruction per cycle.
  - Wait states stretch req with addr unchanged.
- Output register:
  - Held stable while valid&!ready.
  - On transfer: loads from skid if skid valid, else from the same-cycle ack, else valid<=0 and ir_out<=NOP_INSTR.
- Skid register (1 entry):
  - While full, req_out=0.
  - req&ack and skid-full can never coincide.
- Redirect (highest priority, any state except reset):
  - ir_valid<=0, ir_out<=NOP_INSTR, skid cleared.
  - Any same-cycle ack data is discarded, and pc is not incremented by it.
  - Target aligned, no request outstanding (req=0, or req&ack this cycle): pc<=target, state FETCH.
  - Target aligned, request outstanding without ack: pc<=target, state DRAIN.
  - Target misaligned: misaligned<=1, state ERROR, pc unchanged.
- DRAIN:
  - req held with the old address until ack.
  - Ack data is discarded, then -> FETCH at the new pc.
  - A new redirect in DRAIN only updates pc (still waits for ack).
- ERROR:
  - req=0, ir_valid=0.
  - Exits only on an aligned redirect (-> FETCH, misaligned<=0) or reset.
- fetch_ins_mem_addr_out always equals pc, except in DRAIN where it holds the old address.
- Reset mid-request: req drops immediately (async); the memory controller must abandon the transaction.

Test Plan:
- Reset release, zero-wait memory with ack=req, ready=1:
  - Addr 0,4,8,... on consecutive cycles.
  - ir_valid rises one cycle after the first ack.
  - pc_out 0,4,8 with data echoed.
- Memory with 2 wait states:
  - addr 0x0 held 3 cycles with req=1.
  - One instruction every 3 cycles, pc_out increments by 4.
- Backpressure: ready=0 after the first instruction:
  - Second word lands in skid, req drops.
  - ready=1 then releases both in order (pc 0x0 then 0x4) and req resumes at 0x8.
- Redirect to 0x100 while a request to 0x8 waits for ack:
  - addr stays 0x8 until ack, data discarded.
  - Next request addr=0x100; first valid pc_out=0x100.
  - No stale instruction is emitted.
- Redirect to 0x102:
  - misaligned=1, req=0, valid=0.
  - Later redirect to 0x200 clears the flag and fetch resumes at 0x200.
- Counter wrap: redirect to 0xFFFF_FFFC with zero-wait memory:
  - Fetches 0xFFFF_FFFC then 0x0000_0000.
- Assert reset mid-burst:
  - All outputs return to reset values asynchronously.
  - Fetch restarts at RESET_VECTOR.
